apb_gpio_irq: RTL

Parametrised APB GPIO peripheral, the successor to the MCU's fixed 32-bit GPIO slave. It sits on one port of the APB peripheral bus behind the AXI2APB bridge and drives pins to the pad ring. Pin count is configurable, each pin has an optional debounce filter, and each pin has an interrupt mode of level-high/low, rising, falling or both edges, with sticky write-1-to-clear status. A single combined interrupt line goes to the core/event unit.

---
 rtl/apb_gpio_irq.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/apb_gpio_irq.sv
// APB GPIO peripheral with a configurable pin count, per-pin debounce, and per-pin level/edge interrupts.
// The sticky status bits are cleared by writing 1; a set in the same cycle as a clear takes priority.
module apb_gpio_irq #(
    parameter int GPIO_WIDTH     = 32,
    parameter int APB_ADDR_WIDTH = 12,
    parameter int DB_CNT_WIDTH   = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [GPIO_WIDTH-1:0]     gpio_in,
    output logic [GPIO_WIDTH-1:0]     gpio_out,
    output logic [GPIO_WIDTH-1:0]     gpio_dir,
    output logic                      interrupt
);

    localparam logic [3:0] A_DIR        = 4'h0;
    localparam logic [3:0] A_IN         = 4'h1;
    localparam logic [3:0] A_OUT        = 4'h2;
    localparam logic [3:0] A_OUT_SET    = 4'h3;
    localparam logic [3:0] A_OUT_CLR    = 4'h4;
    localparam logic [3:0] A_INT_EN     = 4'h5;
    localparam logic [3:0] A_INT_TYPE   = 4'h6;
    localparam logic [3:0] A_INT_POL    = 4'h7;
    localparam logic [3:0] A_INT_BOTH   = 4'h8;
    localparam logic [3:0] A_INT_STATUS = 4'h9;
    localparam logic [3:0] A_DB_EN      = 4'hA;
    localparam logic [3:0] A_DB_PERIOD  = 4'hB;

    logic                    access;
    logic                    wr;
    logic [3:0]              idx;
    logic                    mapped;
    logic [GPIO_WIDTH-1:0]   wdata;
    logic [31:0]             rdata;
    logic                    unused_bits;

    logic [GPIO_WIDTH-1:0]   dir_q;
    logic [GPIO_WIDTH-1:0]   out_q;
    logic [GPIO_WIDTH-1:0]   int_en_q;
    logic [GPIO_WIDTH-1:0]   int_type_q;
    logic [GPIO_WIDTH-1:0]   int_pol_q;
    logic [GPIO_WIDTH-1:0]   int_both_q;
    logic [GPIO_WIDTH-1:0]   int_status_q;
    logic [GPIO_WIDTH-1:0]   db_en_q;
    logic [DB_CNT_WIDTH-1:0] db_period_q;

    logic [GPIO_WIDTH-1:0]   sync1_q;
    logic [GPIO_WIDTH-1:0]   sync2_q;
    logic [GPIO_WIDTH-1:0]   sample_q;
    logic [GPIO_WIDTH-1:0]   db_filt_q;
    logic [GPIO_WIDTH-1:0]   prev_q;
    logic [DB_CNT_WIDTH-1:0] presc_q;

    logic                    tick;
    logic                    db_period_wr;
    logic [GPIO_WIDTH-1:0]   agree;
    logic [GPIO_WIDTH-1:0]   filtered;
    logic [GPIO_WIDTH-1:0]   rise;
    logic [GPIO_WIDTH-1:0]   fall;
    logic [GPIO_WIDTH-1:0]   edge_hit;
    logic [GPIO_WIDTH-1:0]   level_hit;
    logic [GPIO_WIDTH-1:0]   status_set;
    logic [GPIO_WIDTH-1:0]   status_clr;

    assign access       = PSEL & PENABLE;
    assign wr           = access & PWRITE;
    assign idx          = PADDR[5:2];
    assign mapped       = (idx <= A_DB_PERIOD);
    assign wdata        = PWDATA[GPIO_WIDTH-1:0];
    assign unused_bits  = ^{PADDR, PWDATA};
    assign db_period_wr = wr && (idx == A_DB_PERIOD);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            dir_q       <= '0;
            out_q       <= '0;
            int_en_q    <= '0;
            int_type_q  <= '0;
            int_pol_q   <= '0;
            int_both_q  <= '0;
            db_en_q     <= '0;
            db_period_q <= '0;
        end else if (wr) begin
            case (idx)
                A_DIR:       dir_q       <= wdata;
                A_OUT:       out_q       <= wdata;
                A_OUT_SET:   out_q       <= out_q | wdata;
                A_OUT_CLR:   out_q       <= out_q & ~wdata;
                A_INT_EN:    int_en_q    <= wdata;
                A_INT_TYPE:  int_type_q  <= wdata;
                A_INT_POL:   int_pol_q   <= wdata;
                A_INT_BOTH:  int_both_q  <= wdata;
                A_DB_EN:     db_en_q     <= wdata;
                A_DB_PERIOD: db_period_q <= PWDATA[DB_CNT_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    // Shared prescaler counts 0..DB_PERIOD; tick marks the cycle before it wraps.
    assign tick  = (presc_q == db_period_q);
    assign agree = ~(sync2_q ^ sample_q);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            sample_q  <= '0;
            db_filt_q <= '0;
            prev_q    <= '0;
            presc_q   <= '0;
        end else begin
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
            prev_q  <= filtered;
            if (db_period_wr || tick) begin
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + 1'b1;
            end
            if (tick) begin
                sample_q  <= sync2_q;
                db_filt_q <= (sync2_q & agree) | (db_filt_q & ~agree);
            end
        end
    end

    assign filtered   = (db_en_q & db_filt_q) | (~db_en_q & sync2_q);
    assign rise       = filtered & ~prev_q;
    assign fall       = ~filtered & prev_q;
    assign edge_hit   = (int_both_q & (rise | fall))
                      | (~int_both_q & int_pol_q & rise)
                      | (~int_both_q & ~int_pol_q & fall);
    assign level_hit  = ~(filtered ^ int_pol_q);
    assign status_set = (int_type_q & edge_hit) | (~int_type_q & level_hit);
    assign status_clr = (wr && (idx == A_INT_STATUS)) ? wdata : '0;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            int_status_q <= '0;
        end else begin
            int_status_q <= (int_status_q & ~status_clr) | status_set;
        end
    end

    always_comb begin
        rdata = '0;
        case (idx)
            A_DIR:        rdata = 32'(dir_q);
            A_IN:         rdata = 32'(filtered);
            A_OUT:        rdata = 32'(out_q);
            A_INT_EN:     rdata = 32'(int_en_q);
            A_INT_TYPE:   rdata = 32'(int_type_q);
            A_INT_POL:    rdata = 32'(int_pol_q);
            A_INT_BOTH:   rdata = 32'(int_both_q);
            A_INT_STATUS: rdata = 32'(int_status_q);
            A_DB_EN:      rdata = 32'(db_en_q);
            A_DB_PERIOD:  rdata = 32'(db_period_q);
            default:      rdata = '0;
        endcase
    end

    assign PRDATA    = access ? rdata : 32'h0;
    assign PSLVERR   = access & ~mapped;
    assign PREADY    = 1'b1;
    assign gpio_out  = out_q;
    assign gpio_dir  = dir_q;
    assign interrupt = |(int_status_q & int_en_q);

endmodule
